booth2_mul_seq_iter: RTL and testbench



---
 rtl/booth2_mul_seq_iter_if.sv | 26 ++
 rtl/booth2_mul_seq_iter.sv | 125 ++++++++++++
 tb/tb_booth2_mul_seq_iter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/booth2_mul_seq_iter_if.sv
// Operand/product handshake bundle for the sequential Booth-2 multiplier.
// No latency of its own; valid/ready on both the operand and product sides.
interface booth2_mul_seq_iter_if #(
    parameter int MUL_IN_WD = 32
);
    logic                   val_i;
    logic                   rdy_o;
    logic                   sgn_i;
    logic [MUL_IN_WD-1:0]   ai;
    logic [MUL_IN_WD-1:0]   bi;
    logic                   flush_i;
    logic                   val_o;
    logic                   rdy_i;
    logic [2*MUL_IN_WD-1:0] prod_o;
    logic                   busy_o;

    modport master (
        output val_i, sgn_i, ai, bi, flush_i, rdy_i,
        input  rdy_o, val_o, prod_o, busy_o
    );

    modport slave (
        input  val_i, sgn_i, ai, bi, flush_i, rdy_i,
        output rdy_o, val_o, prod_o, busy_o
    );
endinterface

// File: rtl/booth2_mul_seq_iter.sv
// Sequential radix-4 Booth multiplier retiring PP_PER_CYC digits per clock; result N_ITER cycles after accept.
// Product is held in DONE until rdy_i; operands are accepted only in IDLE.
module booth2_mul_seq_iter #(
    parameter int MUL_IN_WD  = 32,
    parameter int PP_PER_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    booth2_mul_seq_iter_if.slave bus
);
    localparam int NDIG   = MUL_IN_WD / 2 + 1;
    localparam int N_ITER = (NDIG + PP_PER_CYC - 1) / PP_PER_CYC;
    localparam int CNT_WD = $clog2(N_ITER) + 1;
    localparam int EXT_WD = MUL_IN_WD + 2;
    localparam int BSH_WD = EXT_WD + 1;
    localparam int ACC_WD = 2 * MUL_IN_WD + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WD-1:0]      r_cnt;
    logic [ACC_WD-1:0]      r_acc;
    logic [ACC_WD-1:0]      r_a_sh;
    logic [BSH_WD-1:0]      r_b_sh;
    logic [2*MUL_IN_WD-1:0] r_prod;
    logic [ACC_WD-1:0]      w_acc_nxt;
    logic [EXT_WD-1:0]      w_a_ext;
    logic [EXT_WD-1:0]      w_b_ext;
    logic                   w_accept;
    logic                   w_last;

    assign w_a_ext  = {{2{bus.sgn_i & bus.ai[MUL_IN_WD-1]}}, bus.ai};
    assign w_b_ext  = {{2{bus.sgn_i & bus.bi[MUL_IN_WD-1]}}, bus.bi};
    assign w_accept = (r_state == S_IDLE) && bus.val_i && !bus.flush_i;
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_WD'(N_ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (bus.rdy_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush_i) w_state_nxt = S_IDLE;
    end

    always_comb begin
        bus.rdy_o  = (r_state == S_IDLE);
        bus.busy_o = (r_state == S_CALC);
        bus.val_o  = (r_state == S_DONE);
        bus.prod_o = r_prod;
    end

    // r_b_sh[0] is B[-1]; r_a_sh already carries the 4^i weight of digit 0 this cycle.
    always_comb begin
        logic [2:0]        w_trip;
        logic [ACC_WD-1:0] w_mag;
        logic              w_neg;
        w_acc_nxt = r_acc;
        w_trip    = 3'b000;
        w_mag     = '0;
        w_neg     = 1'b0;
        for (int k = 0; k < PP_PER_CYC; k++) begin
            w_trip = r_b_sh[2*k +: 3];
            w_mag  = '0;
            w_neg  = 1'b0;
            case (w_trip)
                3'b001, 3'b010: w_mag = r_a_sh << (2 * k);
                3'b011:         w_mag = r_a_sh << (2 * k + 1);
                3'b100: begin
                    w_mag = r_a_sh << (2 * k + 1);
                    w_neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    w_mag = r_a_sh << (2 * k);
                    w_neg = 1'b1;
                end
                default: begin
                    w_mag = '0;
                    w_neg = 1'b0;
                end
            endcase
            if ((int'(r_cnt) * PP_PER_CYC + k) >= NDIG) begin
                w_mag = '0;
                w_neg = 1'b0;
            end
            w_acc_nxt = w_acc_nxt + (w_mag ^ {ACC_WD{w_neg}}) + ACC_WD'(w_neg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_prod <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a_sh <= {{(ACC_WD - EXT_WD){w_a_ext[EXT_WD-1]}}, w_a_ext};
            r_b_sh <= {w_b_ext, 1'b0};
        end else if ((r_state == S_CALC) && !bus.flush_i) begin
            r_cnt  <= r_cnt + 1'b1;
            r_acc  <= w_acc_nxt;
            r_a_sh <= r_a_sh << (2 * PP_PER_CYC);
            r_b_sh <= $signed(r_b_sh) >>> (2 * PP_PER_CYC);
            if (w_last) r_prod <= w_acc_nxt[2*MUL_IN_WD-1:0];
        end
    end
endmodule

// File: tb/tb_booth2_mul_seq_iter.sv
// Scoreboard bench: a 32-bit one-digit-per-cycle instance and a 16-bit three-digit instance.
// Issued operations push expected products; per-instance monitors pop and compare on handshake.
module tb_booth2_mul_seq_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth2_mul_seq_iter_if #(.MUL_IN_WD(32)) bus0 ();
    booth2_mul_seq_iter_if #(.MUL_IN_WD(16)) bus1 ();

    booth2_mul_seq_iter #(.MUL_IN_WD(32), .PP_PER_CYC(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    booth2_mul_seq_iter #(.MUL_IN_WD(16), .PP_PER_CYC(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for instance 0 (latency 17)
    bit          p0_vld = 1'b0;
    logic [63:0] p0_prod;
    bit          hs0 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            p0_vld = 1'b0;
            hs0    = 1'b0;
        end else begin
            if (hs0) begin
                chk("d0_rdy_after_hs", {63'd0, bus0.rdy_o}, 64'd1);
                chk("d0_val_after_hs", {63'd0, bus0.val_o}, 64'd0);
            end
            hs0 = 1'b0;
            if (bus0.val_o) begin
                if (q0.size() == 0) begin
                    chk("d0_unexpected_val", {63'd0, bus0.val_o}, 64'd0);
                end else begin
                    if (!p0_vld) chk("d0_latency", 64'(cyc - q0[0].acc_cyc), 64'd17);
                    else         chk("d0_prod_stable", bus0.prod_o, p0_prod);
                    if (bus0.rdy_i) begin
                        chk("d0_prod", bus0.prod_o, q0[0].prod);
                        void'(q0.pop_front());
                        hs0 = 1'b1;
                    end
                end
            end
            p0_vld  = bus0.val_o;
            p0_prod = bus0.prod_o;
        end
    end

    // Monitor for instance 1 (latency 3)
    bit          p1_vld = 1'b0;
    logic [31:0] p1_prod;
    bit          hs1 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            p1_vld = 1'b0;
            hs1    = 1'b0;
        end else begin
            if (hs1) chk("d1_rdy_after_hs", {63'd0, bus1.rdy_o}, 64'd1);
            hs1 = 1'b0;
            if (bus1.val_o) begin
                if (q1.size() == 0) begin
                    chk("d1_unexpected_val", {63'd0, bus1.val_o}, 64'd0);
                end else begin
                    if (!p1_vld) chk("d1_latency", 64'(cyc - q1[0].acc_cyc), 64'd3);
                    else         chk("d1_prod_stable", {32'd0, bus1.prod_o}, {32'd0, p1_prod});
                    if (bus1.rdy_i) begin
                        chk("d1_prod", {32'd0, bus1.prod_o}, q1[0].prod);
                        void'(q1.pop_front());
                        hs1 = 1'b1;
                    end
                end
            end
            p1_vld  = bus1.val_o;
            p1_prod = bus1.prod_o;
        end
    end

    task automatic issue0(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit push);
        int n = 0;
        while (!bus0.rdy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus0.rdy_o) chk("d0_rdy_timeout", {63'd0, bus0.rdy_o}, 64'd1);
        bus0.val_i = 1'b1;
        bus0.sgn_i = s;
        bus0.ai    = a;
        bus0.bi    = b;
        @(posedge clk); #1;
        bus0.val_i = 1'b0;
        if (push) q0.push_back('{prod: exp, acc_cyc: cyc});
    endtask

    task automatic issue1(input bit s, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        int n = 0;
        while (!bus1.rdy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus1.rdy_o) chk("d1_rdy_timeout", {63'd0, bus1.rdy_o}, 64'd1);
        bus1.val_i = 1'b1;
        bus1.sgn_i = s;
        bus1.ai    = a;
        bus1.bi    = b;
        @(posedge clk); #1;
        bus1.val_i = 1'b0;
        q1.push_back('{prod: {32'd0, exp}, acc_cyc: cyc});
    endtask

    task automatic wait_val0();
        int n = 0;
        while (!bus0.val_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus0.val_o) chk("d0_val_timeout", {63'd0, bus0.val_o}, 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
    endtask

    function automatic logic [31:0] ref_mul16(input bit s, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sp;
        logic        [31:0] up;
        sp = $signed(a) * $signed(b);
        up = {16'd0, a} * {16'd0, b};
        return s ? sp : up;
    endfunction

    initial begin
        bus0.val_i = 1'b0; bus0.sgn_i = 1'b0; bus0.ai = '0; bus0.bi = '0;
        bus0.flush_i = 1'b0; bus0.rdy_i = 1'b1;
        bus1.val_i = 1'b0; bus1.sgn_i = 1'b0; bus1.ai = '0; bus1.bi = '0;
        bus1.flush_i = 1'b0; bus1.rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_rdy_o",  {63'd0, bus0.rdy_o},  64'd1);
        chk("rst_val_o",  {63'd0, bus0.val_o},  64'd0);
        chk("rst_busy_o", {63'd0, bus0.busy_o}, 64'd0);
        chk("rst_prod_o", bus0.prod_o,          64'd0);

        issue0(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        chk("busy_in_calc", {63'd0, bus0.busy_o}, 64'd1);
        chk("rdy_in_calc",  {63'd0, bus0.rdy_o},  64'd0);
        issue0(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        issue0(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        issue0(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        issue0(1'b1, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 1'b1);
        issue0(1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b1);
        issue0(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
        issue0(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 64'h0000_0006_FFFF_FFEB, 1'b1);
        wait_drain();

        // Backpressure: product held for 5 cycles, operand pulses must be refused
        bus0.rdy_i = 1'b0;
        issue0(1'b1, 32'h0000_0005, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFE7, 1'b1);
        wait_val0();
        bus0.ai = 32'd1; bus0.bi = 32'd1;
        for (int i = 0; i < 5; i++) begin
            bus0.val_i = (i % 2 == 0);
            chk("bp_rdy_o_low", {63'd0, bus0.rdy_o}, 64'd0);
            @(posedge clk); #1;
        end
        bus0.val_i = 1'b0;
        bus0.rdy_i = 1'b1;
        wait_drain();

        // Flush at CALC cycle 8: result discarded
        issue0(1'b1, 32'h0000_0011, 32'h0000_0022, 64'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1 bus0.flush_i = 1'b1;
        bus0.val_i = 1'b1;
        @(posedge clk); #1;
        bus0.flush_i = 1'b0;
        bus0.val_i   = 1'b0;
        chk("flush_rdy_o",  {63'd0, bus0.rdy_o},  64'd1);
        chk("flush_busy_o", {63'd0, bus0.busy_o}, 64'd0);
        repeat (25) @(posedge clk);
        #1;
        issue0(1'b1, 32'd7, 32'd6, 64'd42, 1'b1);
        wait_drain();

        // Narrow instance with three digits per cycle
        issue1(1'b1, 16'h8001, 16'h7FFF, 32'hC000_FFFF);
        issue1(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        issue1(1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            bit          rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            issue1(rs, ra, rb, ref_mul16(rs, ra, rb));
        end
        wait_drain();

        // Reset while a result waits in DONE
        bus0.rdy_i = 1'b0;
        issue0(1'b1, 32'd3, 32'd3, 64'd9, 1'b1);
        wait_val0();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (q0.size() != 0) void'(q0.pop_front());
        chk("rstd_val_o",  {63'd0, bus0.val_o},  64'd0);
        chk("rstd_rdy_o",  {63'd0, bus0.rdy_o},  64'd1);
        chk("rstd_prod_o", bus0.prod_o,          64'd0);
        chk("rstd_busy_o", {63'd0, bus0.busy_o}, 64'd0);
        bus0.rdy_i = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        issue0(1'b0, 32'd100, 32'd100, 64'd10000, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
